// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg -- opcodes, state encoding and instruction field positions.
// Revision 1.0
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_JUMP    = 3'd4,
    ST_HALT    = 3'd5
  } seq_state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BR   = 4'h2;
  localparam logic [3:0] OP_BZ   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPD_MSB = 3;
  localparam int OPD_LSB = 0;

  function automatic logic [3:0] opcode_of(input logic [7:0] byte_in);
    return byte_in[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] operand_of(input logic [7:0] byte_in);
    return byte_in[OPD_MSB:OPD_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_instr_decode.sv
// pc_instr_decode -- classifies the held instruction into the PC action taken in DECODE.
// Revision 1.0
`default_nettype none

module pc_instr_decode
  import pc_sequencer_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       zero_flag,
  output logic       is_jmp,
  output logic       is_rel_taken,
  output logic       is_halt,
  output logic       is_inc
);

  // is_inc also covers JMP, whose first byte advances the PC to the operand.
  always_comb begin
    is_jmp       = 1'b0;
    is_rel_taken = 1'b0;
    is_halt      = 1'b0;
    is_inc       = 1'b0;
    case (opcode_of(ir))
      OP_NOP:  is_inc = 1'b1;
      OP_JMP: begin
        is_jmp = 1'b1;
        is_inc = 1'b1;
      end
      OP_BR:   is_rel_taken = 1'b1;
      OP_BZ: begin
        is_rel_taken = zero_flag;
        is_inc       = ~zero_flag;
      end
      OP_HALT: is_halt = 1'b1;
      default: is_inc = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch/decode sequencer producing IncPC/LoadPC controls for a program counter.
// Revision 1.0
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       CLB,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  input  logic       zero_flag,
  output logic       fetch_req,
  output logic       IncPC,
  output logic       LoadPC,
  output logic       SelPC,
  output logic [7:0] A,
  output logic [3:0] B,
  output logic       halted
);

  seq_state_t state, state_nxt, resume_st;
  logic [7:0] ir, target;
  logic       sel_q;
  logic [7:0] a_q;
  logic [3:0] b_q;
  logic       is_jmp, is_rel_taken, is_halt, is_inc;

  pc_instr_decode u_decode (
    .ir           (ir),
    .zero_flag    (zero_flag),
    .is_jmp       (is_jmp),
    .is_rel_taken (is_rel_taken),
    .is_halt      (is_halt),
    .is_inc       (is_inc)
  );

  // Every instruction boundary parks in IDLE when run is low.
  assign resume_st = run ? ST_FETCH : ST_IDLE;
  assign fetch_req = (state == ST_FETCH) || (state == ST_OPERAND);
  assign halted    = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    IncPC     = 1'b0;
    LoadPC    = 1'b0;
    SelPC     = sel_q;
    A         = a_q;
    B         = b_q;
    case (state)
      ST_IDLE:    if (run) state_nxt = ST_FETCH;
      ST_FETCH:   if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_halt) begin
          state_nxt = ST_HALT;
        end else if (is_rel_taken) begin
          LoadPC    = 1'b1;
          SelPC     = 1'b0;
          B         = operand_of(ir);
          state_nxt = resume_st;
        end else begin
          IncPC     = is_inc;
          state_nxt = is_jmp ? ST_OPERAND : resume_st;
        end
      end
      ST_OPERAND: if (instr_valid) state_nxt = ST_JUMP;
      ST_JUMP: begin
        LoadPC    = 1'b1;
        SelPC     = 1'b1;
        A         = target;
        state_nxt = resume_st;
      end
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state  <= ST_IDLE;
      ir     <= 8'h00;
      target <= 8'h00;
      sel_q  <= 1'b0;
      a_q    <= 8'h00;
      b_q    <= 4'h0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid) ir <= instr;
      if (state == ST_OPERAND && instr_valid) target <= instr;
      if (LoadPC) begin
        sel_q <= SelPC;
        a_q   <= A;
        b_q   <= B;
      end
    end
  end

endmodule

`default_nettype wire
